store_lane_writer: RTL and testbench

Store-side counterpart of the datapath's load/selection muxes. It places byte and halfword store data into the correct lanes of a 32-bit word-addressed memory.
- Word stores: single write.
- Sub-word stores (sb/sh): read-modify-write.
- Sits between the multicycle control unit and the data memory port; the control unit waits on a valid/ready handshake and a done pulse.

---
 rtl/store_lane_pkg.sv | 35 +++
 rtl/lane_merge.sv | 26 ++
 rtl/store_lane_writer.sv | 101 ++++++++++
 tb/tb_store_lane_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_lane_pkg.sv
// Shared types for the sub-word store path: access sizes, controller states
// and the alignment rule applied when a store is accepted.
package store_lane_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Wide enough to count down any memory latency from 1 to 7.
  localparam int WAIT_CW = 3;

  function automatic logic is_misaligned(input logic [1:0] lane, input size_e size);
    logic bad;
    case (size)
      SZ_WORD: bad = (lane != 2'b00);
      SZ_HALF: bad = lane[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Places right-justified store data into its little-endian lanes of the old word.
// Purely combinational; no flow control.
module lane_merge
  import store_lane_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  lane,
  input  size_e       size,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_WORD: merged = st_data;
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = st_data[15:0];
        else         merged[15:0]  = st_data[15:0];
      end
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = st_data[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_lane_writer.sv
// Store unit: word stores write directly (done 2 cycles after accept), sub-word stores
// read-modify-write (done 3+MEM_LATENCY after accept); req_ready only in IDLE, nothing queued.
module store_lane_writer
  import store_lane_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e               state, state_n;
  logic [WAIT_CW-1:0]   wait_cnt, wait_cnt_n;
  logic [31:0]          data_q;
  logic [1:0]           lane_q;
  size_e                size_q;
  size_e                req_sz;
  logic                 accept;
  logic [31:0]          merged;

  assign req_sz = size_e'(req_size);
  assign accept = req_valid && (state == ST_IDLE);

  lane_merge u_merge (
    .old_word (mem_rdata),
    .st_data  (data_q),
    .lane     (lane_q),
    .size     (size_q),
    .merged   (merged)
  );

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_misaligned(req_addr[1:0], req_sz)) state_n = ST_ERR;
          else if (req_sz == SZ_WORD)               state_n = ST_WRITE;
          else                                      state_n = ST_READ;
        end
      end
      ST_READ: begin
        state_n    = ST_WAIT;
        wait_cnt_n = WAIT_CW'(MEM_LATENCY - 1);
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_n = ST_WRITE;
        else                wait_cnt_n = wait_cnt - 1'b1;
      end
      ST_WRITE: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      ST_ERR:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the cycle its state occupies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      data_q     <= '0;
      lane_q     <= '0;
      size_q     <= SZ_WORD;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      req_ready  <= (state_n == ST_IDLE);
      done       <= (state_n == ST_DONE);
      misaligned <= (state_n == ST_ERR);
      mem_wr     <= (state_n == ST_WRITE);
      if (accept) begin
        data_q <= req_data;
        lane_q <= req_addr[1:0];
        size_q <= req_sz;
      end
      if (accept && state_n != ST_ERR) mem_addr <= {req_addr[31:2], 2'b00};
      if (accept && state_n == ST_WRITE) mem_wdata <= req_data;
      else if (state == ST_WAIT && state_n == ST_WRITE) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_lane_writer.sv
// Drives two store units (memory latency 1 and 3) with shared requests and checks each
// against a timeline/byte-memory model of how every accepted store must unfold.
module tb_store_lane_writer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [1:0]  rdy, dn, mis, wr;
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrdata [2];

  store_lane_writer #(.MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(dn[0]), .misaligned(mis[0]), .mem_addr(maddr[0]), .mem_wr(wr[0]),
    .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0])
  );

  store_lane_writer #(.MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(dn[1]), .misaligned(mis[1]), .mem_addr(maddr[1]), .mem_wr(wr[1]),
    .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: per unit, one outstanding store described by its accept cycle and kind
  // (0 rejected, 1 word, 2 sub-word); memory is a plain byte array.
  logic [7:0]  mem [2][256];
  bit          busy [2];
  int          t0 [2];
  int          kind [2];
  logic [31:0] op_addr [2];
  logic [31:0] expw [2];
  int          wr_off [2], done_off [2], mis_off [2];
  logic [31:0] last_wdata [2], last_waddr [2];

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int end_off(int i);
    return (kind[i] == 0) ? 2 : (kind[i] == 1) ? 3 : 4 + lat(i);
  endfunction

  function automatic int wr_at(int i);
    return (kind[i] == 0) ? -1 : (kind[i] == 1) ? 1 : 2 + lat(i);
  endfunction

  function automatic int done_at(int i);
    return (kind[i] == 0) ? -1 : (kind[i] == 1) ? 2 : 3 + lat(i);
  endfunction

  function automatic logic [31:0] rd_word(int i, logic [31:0] a);
    return {mem[i][{a[7:2], 2'd3}], mem[i][{a[7:2], 2'd2}],
            mem[i][{a[7:2], 2'd1}], mem[i][{a[7:2], 2'd0}]};
  endfunction

  function automatic void model_accept(int i);
    logic [7:0] b [4];
    if (!reset_n || !req_valid || busy[i]) return;
    busy[i]    = 1'b1;
    t0[i]      = cyc;
    op_addr[i] = req_addr;
    if (req_size == 2'd3 || (req_size == 2'd0 && req_addr[1:0] != 2'd0) ||
        (req_size == 2'd1 && req_addr[0])) begin
      kind[i] = 0;
    end else if (req_size == 2'd0) begin
      kind[i] = 1;
      expw[i] = req_data;
    end else begin
      kind[i] = 2;
      for (int k = 0; k < 4; k++) b[k] = mem[i][{req_addr[7:2], 2'(k)}];
      b[req_addr[1:0]] = req_data[7:0];
      if (req_size == 2'd1) b[req_addr[1:0] + 2'd1] = req_data[15:8];
      expw[i] = {b[3], b[2], b[1], b[0]};
    end
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int   off;
      logic e_wr;
      off  = cyc - t0[i];
      e_wr = busy[i] && off == wr_at(i);
      chk("req_ready", i, 32'(rdy[i]), 32'(!busy[i]));
      chk("mem_wr", i, 32'(wr[i]), 32'(e_wr));
      chk("done", i, 32'(dn[i]), 32'(busy[i] && off == done_at(i)));
      chk("misaligned", i, 32'(mis[i]), 32'(busy[i] && kind[i] == 0 && off == 1));
      if (busy[i] && kind[i] != 0 && off >= 1 && off <= wr_at(i))
        chk("mem_addr", i, maddr[i], {op_addr[i][31:2], 2'b00});
      if (e_wr) begin
        chk("mem_wdata", i, mwdata[i], expw[i]);
        for (int k = 0; k < 4; k++) mem[i][{op_addr[i][7:2], 2'(k)}] = expw[i][8*k +: 8];
      end
      if (wr[i])  begin wr_off[i] = off; last_wdata[i] = mwdata[i]; last_waddr[i] = maddr[i]; end
      if (dn[i])  done_off[i] = off;
      if (mis[i]) mis_off[i] = off;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_accept(i);
    cyc++;
    for (int i = 0; i < 2; i++)
      if (busy[i] && cyc - t0[i] == end_off(i)) busy[i] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      mrdata[i] = (busy[i] && kind[i] == 2 && cyc - t0[i] == 1 + lat(i)) ?
                  rd_word(i, op_addr[i]) : $urandom;
    @(negedge clk);
    compare();
  endtask

  task automatic clr_rec();
    for (int i = 0; i < 2; i++) begin
      wr_off[i] = -1; done_off[i] = -1; mis_off[i] = -1;
      last_wdata[i] = '0; last_waddr[i] = '0;
    end
  endtask

  task automatic set_word(logic [31:0] a, logic [31:0] v);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) mem[i][{a[7:2], 2'(k)}] = v[8*k +: 8];
  endtask

  task automatic run_op(logic [31:0] a, logic [31:0] d, logic [1:0] s);
    clr_rec();
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    logic [31:0] ma [3];
    logic [1:0]  ms [3];
    reset_n = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mrdata[0] = '0; mrdata[1] = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; t0[i] = 0; kind[i] = 0;
      for (int j = 0; j < 256; j++) mem[i][j] = 8'($urandom);
    end
    clr_rec();
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(rdy[i]), 32'd1);
      chk("rst_wr", i, 32'(wr[i]), 32'd0);
      chk("rst_done", i, 32'(dn[i]), 32'd0);
      chk("rst_mis", i, 32'(mis[i]), 32'd0);
      chk("rst_addr", i, maddr[i], 32'd0);
      chk("rst_wdata", i, mwdata[i], 32'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(32'h0000_0010, 32'hDEAD_BEEF, 2'd0);
    for (int i = 0; i < 2; i++) begin
      chk("word_wr_cycle", i, wr_off[i], 32'd1);
      chk("word_done_cycle", i, done_off[i], 32'd2);
      chk("word_wdata", i, last_wdata[i], 32'hDEAD_BEEF);
      chk("word_addr", i, last_waddr[i], 32'h10);
    end

    set_word(32'h20, 32'h1122_3344);
    run_op(32'h0000_0023, 32'h0000_00AB, 2'd2);
    chk("byte_wr_cycle", 0, wr_off[0], 32'd3);
    chk("byte_done_cycle", 0, done_off[0], 32'd4);
    chk("byte_wr_cycle", 1, wr_off[1], 32'd5);
    chk("byte_done_cycle", 1, done_off[1], 32'd6);
    for (int i = 0; i < 2; i++) begin
      chk("byte_wdata", i, last_wdata[i], 32'hAB22_3344);
      chk("byte_addr", i, last_waddr[i], 32'h20);
    end

    set_word(32'h40, 32'h1122_3344);
    run_op(32'h0000_0042, 32'hFFFF_5566, 2'd1);
    for (int i = 0; i < 2; i++) chk("half_hi_wdata", i, last_wdata[i], 32'h5566_3344);
    set_word(32'h40, 32'h1122_3344);
    run_op(32'h0000_0040, 32'hFFFF_5566, 2'd1);
    for (int i = 0; i < 2; i++) chk("half_lo_wdata", i, last_wdata[i], 32'h1122_5566);

    ma[0] = 32'h01; ms[0] = 2'd1;
    ma[1] = 32'h06; ms[1] = 2'd0;
    ma[2] = 32'h0C; ms[2] = 2'd3;
    for (int c = 0; c < 3; c++) begin
      run_op(ma[c], 32'h5A5A_5A5A, ms[c]);
      for (int i = 0; i < 2; i++) begin
        chk("mis_cycle", i, mis_off[i], 32'd1);
        chk("mis_no_write", i, wr_off[i], 32'hFFFF_FFFF);
        chk("mis_no_done", i, done_off[i], 32'hFFFF_FFFF);
      end
    end

    // Latency-3 byte store with requests waved at it while it waits on memory.
    set_word(32'h08, 32'hCAFE_F00D);
    clr_rec();
    req_addr = 32'h08; req_data = 32'h0000_0077; req_size = 2'd2; req_valid = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      req_valid = (j >= 2 && j <= 4);
      req_addr  = $urandom; req_data = $urandom; req_size = 2'($urandom_range(0, 3));
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    chk("lat3_wr_cycle", 1, wr_off[1], 32'd5);
    chk("lat3_done_cycle", 1, done_off[1], 32'd6);
    chk("lat3_wdata", 1, last_wdata[1], 32'hCAFE_F077);
    chk("lat3_addr", 1, last_waddr[1], 32'h08);

    // Reset while both units sit in their wait phase.
    clr_rec();
    req_addr = 32'h31; req_data = 32'h0000_00EE; req_size = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_ready", i, 32'(rdy[i]), 32'd1);
      chk("rst_mid_wr", i, 32'(wr[i]), 32'd0);
      chk("rst_mid_addr", i, maddr[i], 32'd0);
      busy[i] = 1'b0;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_abandon_wr", i, wr_off[i], 32'hFFFF_FFFF);
      chk("rst_abandon_done", i, done_off[i], 32'hFFFF_FFFF);
    end
    run_op(32'h0000_0044, 32'h1234_5678, 2'd0);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_wdata", i, last_wdata[i], 32'h1234_5678);
      chk("post_rst_wr_cycle", i, wr_off[i], 32'd1);
    end

    repeat (600) begin
      req_addr  = $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      req_valid = ($urandom_range(0, 1) == 1);
      tick();
    end
    req_valid = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
